// File: rtl/rs_if.sv
// Issue, broadcast and dispatch signals of the reservation station.
// Issue is valid-only with rs_full as back-pressure (source must not issue while rs_full is high); dispatch and broadcasts are valid-only, sampled at the edge.
interface rs_if #(
  parameter int OPENUM_W  = 6,
  parameter int ROB_POS_W = 5
);
  logic                 rdy;
  logic                 clr;
  logic                 issue_enable;
  logic [OPENUM_W-1:0]  issue_openum;
  logic [ROB_POS_W-1:0] issue_rob_pos;
  logic                 issue_rs1_ready;
  logic [31:0]          issue_rs1_val;
  logic [ROB_POS_W-1:0] issue_rs1_tag;
  logic                 issue_rs2_ready;
  logic [31:0]          issue_rs2_val;
  logic [ROB_POS_W-1:0] issue_rs2_tag;
  logic [31:0]          issue_imm;
  logic [31:0]          issue_pc;
  logic                 alu_bc_enable;
  logic [ROB_POS_W-1:0] alu_bc_rob_pos;
  logic [31:0]          alu_bc_val;
  logic                 lsb_bc_enable;
  logic [ROB_POS_W-1:0] lsb_bc_rob_pos;
  logic [31:0]          lsb_bc_val;
  logic                 rs_full;
  logic                 rs_to_alu_enable;
  logic [OPENUM_W-1:0]  rs_to_alu_openum;
  logic [ROB_POS_W-1:0] rs_to_alu_rob_pos;
  logic [31:0]          rs_to_alu_rs1_val;
  logic [31:0]          rs_to_alu_rs2_val;
  logic [31:0]          rs_to_alu_imm;
  logic [31:0]          rs_to_alu_pc;

  modport slave (
    input  rdy, clr, issue_enable, issue_openum, issue_rob_pos,
           issue_rs1_ready, issue_rs1_val, issue_rs1_tag,
           issue_rs2_ready, issue_rs2_val, issue_rs2_tag, issue_imm, issue_pc,
           alu_bc_enable, alu_bc_rob_pos, alu_bc_val,
           lsb_bc_enable, lsb_bc_rob_pos, lsb_bc_val,
    output rs_full, rs_to_alu_enable, rs_to_alu_openum, rs_to_alu_rob_pos,
           rs_to_alu_rs1_val, rs_to_alu_rs2_val, rs_to_alu_imm, rs_to_alu_pc
  );

  modport master (
    output rdy, clr, issue_enable, issue_openum, issue_rob_pos,
           issue_rs1_ready, issue_rs1_val, issue_rs1_tag,
           issue_rs2_ready, issue_rs2_val, issue_rs2_tag, issue_imm, issue_pc,
           alu_bc_enable, alu_bc_rob_pos, alu_bc_val,
           lsb_bc_enable, lsb_bc_rob_pos, lsb_bc_val,
    input  rs_full, rs_to_alu_enable, rs_to_alu_openum, rs_to_alu_rob_pos,
           rs_to_alu_rs1_val, rs_to_alu_rs2_val, rs_to_alu_imm, rs_to_alu_pc
  );
endinterface

// File: rtl/reservation_station.sv
// ALU reservation station: holds issued ops until both operands are ready,
// snoops ALU/LSB broadcasts for wakeup and dispatches one ready op per cycle.
module reservation_station #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_POS_W = 5,
  parameter int OPENUM_W  = 6
) (
  input logic clk,
  input logic rst,
  rs_if.slave bus
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0]   busy_q, busy_d, r1_q, r1_d, r2_q, r2_d;
  logic [OPENUM_W-1:0]  op_q  [RS_SIZE];
  logic [OPENUM_W-1:0]  op_d  [RS_SIZE];
  logic [ROB_POS_W-1:0] rob_q [RS_SIZE];
  logic [ROB_POS_W-1:0] rob_d [RS_SIZE];
  logic [ROB_POS_W-1:0] q1_q  [RS_SIZE];
  logic [ROB_POS_W-1:0] q1_d  [RS_SIZE];
  logic [ROB_POS_W-1:0] q2_q  [RS_SIZE];
  logic [ROB_POS_W-1:0] q2_d  [RS_SIZE];
  logic [31:0]          v1_q  [RS_SIZE];
  logic [31:0]          v1_d  [RS_SIZE];
  logic [31:0]          v2_q  [RS_SIZE];
  logic [31:0]          v2_d  [RS_SIZE];
  logic [31:0]          imm_q [RS_SIZE];
  logic [31:0]          imm_d [RS_SIZE];
  logic [31:0]          pc_q  [RS_SIZE];
  logic [31:0]          pc_d  [RS_SIZE];

  logic                 en_q, en_d;
  logic [OPENUM_W-1:0]  out_op_q, out_op_d;
  logic [ROB_POS_W-1:0] out_rob_q, out_rob_d;
  logic [31:0]          out_v1_q, out_v1_d, out_v2_q, out_v2_d;
  logic [31:0]          out_imm_q, out_imm_d, out_pc_q, out_pc_d;

  logic [IDX_W-1:0]     free_idx, disp_idx;
  logic                 free_found, disp_found;
  logic [CNT_W-1:0]     busy_cnt;
  logic [RS_SIZE-1:0]   ready_vec;
  logic                 i1_r, i2_r;
  logic [31:0]          i1_v, i2_v;

  always_comb begin
    busy_d = busy_q; r1_d = r1_q; r2_d = r2_q;
    op_d = op_q; rob_d = rob_q; q1_d = q1_q; q2_d = q2_q;
    v1_d = v1_q; v2_d = v2_q; imm_d = imm_q; pc_d = pc_q;
    en_d = en_q; out_op_d = out_op_q; out_rob_d = out_rob_q;
    out_v1_d = out_v1_q; out_v2_d = out_v2_q;
    out_imm_d = out_imm_q; out_pc_d = out_pc_q;

    // Both selections look only at pre-edge state; scanning downward leaves the lowest index.
    ready_vec  = busy_q & r1_q & r2_q;
    free_idx   = '0; free_found = 1'b0;
    disp_idx   = '0; disp_found = 1'b0;
    busy_cnt   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
      if (ready_vec[i]) begin
        disp_idx   = IDX_W'(i);
        disp_found = 1'b1;
      end
      busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
    end

    // Same-cycle broadcast bypass for the incoming operands; ALU has priority.
    i1_r = bus.issue_rs1_ready; i1_v = bus.issue_rs1_val;
    if (!bus.issue_rs1_ready) begin
      if (bus.alu_bc_enable && bus.alu_bc_rob_pos == bus.issue_rs1_tag) begin
        i1_r = 1'b1; i1_v = bus.alu_bc_val;
      end else if (bus.lsb_bc_enable && bus.lsb_bc_rob_pos == bus.issue_rs1_tag) begin
        i1_r = 1'b1; i1_v = bus.lsb_bc_val;
      end
    end
    i2_r = bus.issue_rs2_ready; i2_v = bus.issue_rs2_val;
    if (!bus.issue_rs2_ready) begin
      if (bus.alu_bc_enable && bus.alu_bc_rob_pos == bus.issue_rs2_tag) begin
        i2_r = 1'b1; i2_v = bus.alu_bc_val;
      end else if (bus.lsb_bc_enable && bus.lsb_bc_rob_pos == bus.issue_rs2_tag) begin
        i2_r = 1'b1; i2_v = bus.lsb_bc_val;
      end
    end

    if (bus.clr) begin
      busy_d = '0;
      en_d = 1'b0; out_op_d = '0; out_rob_d = '0;
      out_v1_d = '0; out_v2_d = '0; out_imm_d = '0; out_pc_d = '0;
    end else if (bus.rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && !r1_q[i]) begin
          if (bus.alu_bc_enable && bus.alu_bc_rob_pos == q1_q[i]) begin
            r1_d[i] = 1'b1; v1_d[i] = bus.alu_bc_val;
          end else if (bus.lsb_bc_enable && bus.lsb_bc_rob_pos == q1_q[i]) begin
            r1_d[i] = 1'b1; v1_d[i] = bus.lsb_bc_val;
          end
        end
        if (busy_q[i] && !r2_q[i]) begin
          if (bus.alu_bc_enable && bus.alu_bc_rob_pos == q2_q[i]) begin
            r2_d[i] = 1'b1; v2_d[i] = bus.alu_bc_val;
          end else if (bus.lsb_bc_enable && bus.lsb_bc_rob_pos == q2_q[i]) begin
            r2_d[i] = 1'b1; v2_d[i] = bus.lsb_bc_val;
          end
        end
      end

      en_d = disp_found;
      if (disp_found) begin
        busy_d[disp_idx] = 1'b0;
        out_op_d  = op_q[disp_idx];
        out_rob_d = rob_q[disp_idx];
        out_v1_d  = v1_q[disp_idx];
        out_v2_d  = v2_q[disp_idx];
        out_imm_d = imm_q[disp_idx];
        out_pc_d  = pc_q[disp_idx];
      end

      if (bus.issue_enable && free_found) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = bus.issue_openum;
        rob_d[free_idx]  = bus.issue_rob_pos;
        r1_d[free_idx]   = i1_r;
        v1_d[free_idx]   = i1_v;
        q1_d[free_idx]   = bus.issue_rs1_tag;
        r2_d[free_idx]   = i2_r;
        v2_d[free_idx]   = i2_v;
        q2_d[free_idx]   = bus.issue_rs2_tag;
        imm_d[free_idx]  = bus.issue_imm;
        pc_d[free_idx]   = bus.issue_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0; r1_q <= '0; r2_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i] <= '0; rob_q[i] <= '0; q1_q[i] <= '0; q2_q[i] <= '0;
        v1_q[i] <= '0; v2_q[i] <= '0; imm_q[i] <= '0; pc_q[i] <= '0;
      end
      en_q <= 1'b0; out_op_q <= '0; out_rob_q <= '0;
      out_v1_q <= '0; out_v2_q <= '0; out_imm_q <= '0; out_pc_q <= '0;
    end else begin
      busy_q <= busy_d; r1_q <= r1_d; r2_q <= r2_d;
      op_q <= op_d; rob_q <= rob_d; q1_q <= q1_d; q2_q <= q2_d;
      v1_q <= v1_d; v2_q <= v2_d; imm_q <= imm_d; pc_q <= pc_d;
      en_q <= en_d; out_op_q <= out_op_d; out_rob_q <= out_rob_d;
      out_v1_q <= out_v1_d; out_v2_q <= out_v2_d;
      out_imm_q <= out_imm_d; out_pc_q <= out_pc_d;
    end
  end

  // One slot of margin: an issue accepted this cycle is only visible in busy next cycle.
  assign bus.rs_full           = busy_cnt >= CNT_W'(RS_SIZE - 1);
  assign bus.rs_to_alu_enable  = en_q;
  assign bus.rs_to_alu_openum  = out_op_q;
  assign bus.rs_to_alu_rob_pos = out_rob_q;
  assign bus.rs_to_alu_rs1_val = out_v1_q;
  assign bus.rs_to_alu_rs2_val = out_v2_q;
  assign bus.rs_to_alu_imm     = out_imm_q;
  assign bus.rs_to_alu_pc      = out_pc_q;
endmodule
